// File: rtl/utmi_tx_path.sv
`default_nettype none
// ============================================================================
// Module   : utmi_tx_path
// Purpose  : UTMI transmit path. Takes parallel words from the SIE over a
//            TxValid/TxReady handshake, frames them with SYNC and EOP,
//            serialises LSB-first, bit-stuffs data after STUFF_LEN ones and
//            NRZI-encodes onto a single registered line bit.
// Ports    : clk       - bit clock, one line bit per cycle
//            rst       - asynchronous active-high reset
//            tx_valid  - SIE has a word on data_in / packet in progress
//            data_in   - word to transmit (DATA_W bits, low byte first)
//            tx_ready  - word accepted at this edge when tx_valid=1 (comb.)
//            line_out  - NRZI line bit (registered, idles at 1)
//            line_oe   - driver enable (registered), covers SYNC..EOP
// Revision : 1.0 - initial release
// ============================================================================
module utmi_tx_path #(
    parameter int DATA_W    = 8,
    parameter int STUFF_LEN = 6,
    parameter int SYNC_LEN  = 32,
    parameter int EOP_LEN   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              tx_ready,
    output logic              line_out,
    output logic              line_oe
);

    localparam int                    c_BCNT_W    = $clog2(DATA_W);
    localparam logic [c_BCNT_W-1:0]   c_BCNT_LAST = c_BCNT_W'(DATA_W - 1);
    localparam logic [3:0]            c_STUFF     = 4'(STUFF_LEN);
    localparam logic [6:0]            c_SYNC_LAST = 7'(SYNC_LEN - 1);
    localparam logic [6:0]            c_EOP_LAST  = 7'(EOP_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SYNC = 2'd1,
        S_DATA = 2'd2,
        S_EOP  = 2'd3
    } state_t;

    state_t              r_state,     w_state_n;
    logic [DATA_W-1:0]   r_hold,      w_hold_n;
    logic                r_hold_full, w_hold_full_n;
    logic [DATA_W-1:0]   r_shreg,     w_shreg_n;
    logic [c_BCNT_W-1:0] r_bcnt,      w_bcnt_n;
    logic [3:0]          r_scnt,      w_scnt_n;
    logic [6:0]          r_pcnt,      w_pcnt_n;   // bit position inside SYNC / EOP
    logic                r_drain,     w_drain_n;  // last word sent, one stuff bit owed
    logic                r_line,      w_line_n;
    logic                r_oe,        w_oe_n;

    logic                w_accept;
    logic                w_emit;        // an encoded bit goes onto the line this slot
    logic                w_bit;         // unencoded value of that bit
    logic [3:0]          w_scnt_data;   // run length after emitting shreg[0]

    assign tx_ready = !r_hold_full && (r_state == S_SYNC || r_state == S_DATA);
    assign line_out = r_line;
    assign line_oe  = r_oe;

    always_comb begin
        w_state_n     = r_state;
        w_hold_n      = r_hold;
        w_hold_full_n = r_hold_full;
        w_shreg_n     = r_shreg;
        w_bcnt_n      = r_bcnt;
        w_scnt_n      = r_scnt;
        w_pcnt_n      = r_pcnt;
        w_drain_n     = r_drain;
        w_line_n      = r_line;
        w_oe_n        = r_oe;
        w_emit        = 1'b0;
        w_bit         = 1'b1;
        w_accept      = tx_valid && tx_ready;
        w_scnt_data   = r_shreg[0] ? (r_scnt + 4'd1) : 4'd0;

        // Accept and reload are mutually exclusive (empty vs full hold),
        // so a later reload assignment below never hides an accept.
        if (w_accept) begin
            w_hold_n      = data_in;
            w_hold_full_n = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                w_oe_n        = 1'b0;
                w_line_n      = 1'b1;
                w_scnt_n      = 4'd0;
                w_pcnt_n      = 7'd0;
                w_drain_n     = 1'b0;
                w_bcnt_n      = '0;
                // A word that arrived too late for the previous packet must
                // not leak into the next one.
                w_hold_full_n = 1'b0;
                if (tx_valid) begin
                    // First SYNC bit is a 0, i.e. a toggle away from idle J.
                    w_state_n = S_SYNC;
                    w_oe_n    = 1'b1;
                    w_line_n  = 1'b0;
                    w_pcnt_n  = 7'd1;
                end
            end

            S_SYNC: begin
                w_emit = 1'b1;
                if (r_pcnt == c_SYNC_LAST) begin
                    w_bit    = 1'b1;
                    w_scnt_n = 4'd1;   // trailing SYNC 1 starts the stuff run
                    w_pcnt_n = 7'd0;
                    if (r_hold_full) begin
                        w_shreg_n     = r_hold;
                        w_hold_full_n = 1'b0;
                        w_bcnt_n      = '0;
                        w_state_n     = S_DATA;
                    end else begin
                        w_state_n = S_EOP;
                    end
                end else begin
                    w_bit    = 1'b0;
                    w_scnt_n = 4'd0;
                    w_pcnt_n = r_pcnt + 7'd1;
                end
            end

            S_DATA: begin
                w_emit = 1'b1;
                if (r_scnt == c_STUFF) begin
                    // Stuff slot: data pipeline frozen for one bit.
                    w_bit    = 1'b0;
                    w_scnt_n = 4'd0;
                    if (r_drain) begin
                        w_drain_n = 1'b0;
                        w_state_n = S_EOP;
                        w_pcnt_n  = 7'd0;
                    end
                end else begin
                    w_bit     = r_shreg[0];
                    w_scnt_n  = w_scnt_data;
                    w_shreg_n = r_shreg >> 1;
                    w_bcnt_n  = r_bcnt + 1'b1;
                    if (r_bcnt == c_BCNT_LAST) begin
                        w_bcnt_n = '0;
                        if (r_hold_full) begin
                            w_shreg_n     = r_hold;
                            w_hold_full_n = 1'b0;
                        end else if (w_scnt_data == c_STUFF) begin
                            // Final bit completed a run: owe one stuff 0 first.
                            w_drain_n = 1'b1;
                        end else begin
                            w_state_n = S_EOP;
                            w_pcnt_n  = 7'd0;
                        end
                    end
                end
            end

            S_EOP: begin
                w_emit = 1'b1;
                w_bit  = (r_pcnt != 7'd0);
                if (r_pcnt == c_EOP_LAST) begin
                    w_state_n = S_IDLE;
                    w_pcnt_n  = 7'd0;
                end else begin
                    w_pcnt_n = r_pcnt + 7'd1;
                end
            end

            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        // NRZI: a 0 toggles the line, a 1 holds it.
        if (w_emit) begin
            w_line_n = w_bit ? r_line : ~r_line;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shreg     <= '0;
            r_bcnt      <= '0;
            r_scnt      <= 4'd0;
            r_pcnt      <= 7'd0;
            r_drain     <= 1'b0;
            r_line      <= 1'b1;
            r_oe        <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_hold      <= w_hold_n;
            r_hold_full <= w_hold_full_n;
            r_shreg     <= w_shreg_n;
            r_bcnt      <= w_bcnt_n;
            r_scnt      <= w_scnt_n;
            r_pcnt      <= w_pcnt_n;
            r_drain     <= w_drain_n;
            r_line      <= w_line_n;
            r_oe        <= w_oe_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_utmi_tx_path.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_utmi_tx_path
// Purpose  : Directed self-checking bench for utmi_tx_path. Three instances
//            (DATA_W=8, DATA_W=16, STUFF_LEN=3) are driven one packet at a
//            time; the line is NRZI-decoded and compared with hand-written
//            bit streams.
// Revision : 1.0 - initial release
// ============================================================================
module tb_utmi_tx_path;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       tv8,  tv16,  tvs3;
    logic [7:0] d8,   ds3;
    logic [15:0] d16;
    logic       rdy8, lo8,  oe8;
    logic       rdy16, lo16, oe16;
    logic       rdys3, los3, oes3;

    utmi_tx_path #(.DATA_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .tx_valid(tv8), .data_in(d8),
        .tx_ready(rdy8), .line_out(lo8), .line_oe(oe8));

    utmi_tx_path #(.DATA_W(16)) u_dut16 (
        .clk(clk), .rst(rst), .tx_valid(tv16), .data_in(d16),
        .tx_ready(rdy16), .line_out(lo16), .line_oe(oe16));

    utmi_tx_path #(.DATA_W(8), .STUFF_LEN(3)) u_dut_s3 (
        .clk(clk), .rst(rst), .tx_valid(tvs3), .data_in(ds3),
        .tx_ready(rdys3), .line_out(los3), .line_oe(oes3));

    int           vectors    = 0;
    int           miscompares = 0;
    logic [255:0] rec, expv;
    int           rec_len, exp_len, rv_cnt;
    logic         end_line;
    bit           done;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_clear();
        expv    = '0;
        exp_len = 0;
    endtask

    task automatic put(input int n, input logic b);
        for (int i = 0; i < n; i++) begin
            expv[exp_len] = b;
            exp_len++;
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic [15:0] w);
        case (sel)
            0:       begin tv8  = v; d8  = w[7:0]; end
            1:       begin tv16 = v; d16 = w;      end
            default: begin tvs3 = v; ds3 = w[7:0]; end
        endcase
    endtask

    // {tx_ready, line_out, line_oe} of the selected instance
    function automatic logic [2:0] outs(input int sel);
        case (sel)
            0:       return {rdy8,  lo8,  oe8};
            1:       return {rdy16, lo16, oe16};
            default: return {rdys3, los3, oes3};
        endcase
    endfunction

    // Sends nw words (w0 then w1) starting from IDLE; tx_valid is held for
    // the first cycle even when nw==0. Records the NRZI-decoded stream while
    // line_oe is high. Called and returns on a negedge.
    task automatic run_pkt(input int sel, input int nw, input logic [15:0] w0, input logic [15:0] w1);
        int         idx;
        logic       prev;
        bit         started;
        logic       v;
        logic [2:0] o;
        idx = 0; prev = 1'b1; started = 0; done = 0;
        rec = '0; rec_len = 0; rv_cnt = 0; end_line = 1'bx;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            v = (cyc == 0) || (idx < nw);
            drive(sel, v, (idx == 0) ? w0 : w1);
            o = outs(sel);
            if (v && o[2]) begin
                rv_cnt++;
                idx++;
            end
            @(negedge clk);
            o = outs(sel);
            if (o[0]) begin
                started = 1;
                if (rec_len < 256) rec[rec_len] = (o[1] === prev);
                rec_len++;
                prev = o[1];
            end else if (started) begin
                done     = 1;
                end_line = o[1];
            end
        end
        drive(sel, 1'b0, 16'h0000);
        check("pkt_complete", {255'b0, done}, 256'd1);
    endtask

    initial begin
        rst = 1'b1;
        tv8 = 0; tv16 = 0; tvs3 = 0; d8 = 0; d16 = 0; ds3 = 0;
        #23;
        check("rst_line_out", {255'b0, lo8},  256'd1);
        check("rst_line_oe",  {255'b0, oe8},  256'd0);
        check("rst_tx_ready", {255'b0, rdy8}, 256'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_oe", {255'b0, oe8}, 256'd0);

        // One byte 0x00, valid dropped after the accept
        run_pkt(0, 1, 16'h0000, 16'h0000);
        exp_clear(); put(31, 0); put(1, 1); put(8, 0); put(1, 0); put(7, 1);
        check("b00_len",    rec_len, exp_len);
        check("b00_bits",   rec, expv);
        check("b00_accept", rv_cnt, 1);
        check("b00_idle",   {255'b0, end_line}, 256'd1);
        repeat (2) @(negedge clk);

        // Two bytes 0xFF: stuff after the 5th and 11th data bits
        run_pkt(0, 2, 16'h00FF, 16'h00FF);
        exp_clear(); put(31, 0); put(1, 1);
        put(5, 1); put(1, 0); put(6, 1); put(1, 0); put(5, 1);
        put(1, 0); put(7, 1);
        check("ff_len",    rec_len, exp_len);
        check("ff_bits",   rec, expv);
        check("ff_accept", rv_cnt, 2);
        repeat (2) @(negedge clk);

        // Zero-length packet
        run_pkt(0, 0, 16'h0000, 16'h0000);
        exp_clear(); put(31, 0); put(1, 1); put(1, 0); put(7, 1);
        check("zlp_len",   rec_len, exp_len);
        check("zlp_bits",  rec, expv);
        check("zlp_ready", rv_cnt, 0);
        repeat (2) @(negedge clk);

        // Reset asserted in the middle of SYNC
        tv8 = 1'b1;
        @(negedge clk);
        tv8 = 1'b0;
        repeat (4) @(negedge clk);
        check("msync_oe_before",  {255'b0, oe8},  256'd1);
        check("msync_rdy_before", {255'b0, rdy8}, 256'd1);
        #2 rst = 1'b1;
        #1;
        check("msync_rst_line", {255'b0, lo8},  256'd1);
        check("msync_rst_oe",   {255'b0, oe8},  256'd0);
        check("msync_rst_rdy",  {255'b0, rdy8}, 256'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("msync_post_oe",   {255'b0, oe8},  256'd0);
        check("msync_post_line", {255'b0, lo8},  256'd1);
        check("msync_post_rdy",  {255'b0, rdy8}, 256'd0);

        // DATA_W=16, 0xA53C: low byte first, LSB-first
        run_pkt(1, 1, 16'hA53C, 16'h0000);
        exp_clear(); put(31, 0); put(1, 1);
        put(2, 0); put(4, 1); put(2, 0);                             // 0x3C
        put(1, 1); put(1, 0); put(1, 1); put(2, 0); put(1, 1);
        put(1, 0); put(1, 1);                                        // 0xA5
        put(1, 0); put(7, 1);
        check("w16_len",  rec_len, exp_len);
        check("w16_bits", rec, expv);
        check("w16_loop", rec[47:32], 256'h0000A53C);
        repeat (2) @(negedge clk);

        // STUFF_LEN=3, 0x07: SYNC 1 + two data ones reach the limit
        run_pkt(2, 1, 16'h0007, 16'h0000);
        exp_clear(); put(31, 0); put(1, 1);
        put(2, 1); put(1, 0); put(1, 1); put(5, 0);
        put(1, 0); put(7, 1);
        check("s3_07_len",  rec_len, exp_len);
        check("s3_07_bits", rec, expv);
        repeat (2) @(negedge clk);

        // STUFF_LEN=3, 0xE0: run completes on the final bit, stuff before EOP
        run_pkt(2, 1, 16'h00E0, 16'h0000);
        exp_clear(); put(31, 0); put(1, 1);
        put(5, 0); put(3, 1); put(1, 0);
        put(1, 0); put(7, 1);
        check("s3_e0_len",  rec_len, exp_len);
        check("s3_e0_bits", rec, expv);
        check("s3_e0_idle", {255'b0, end_line}, 256'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
